// File: rtl/data_sync_rx.sv
// Destination-side bus synchronizer: a level enable from a foreign domain passes through a flop chain,
// and each assertion captures the bus once, emits a one-cycle strobe and flips a toggle acknowledge.
module data_sync_rx #(
  parameter int NUM_STAGES = 2,
  parameter int BUS_WIDTH  = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] Unsync_bus,
  input  logic                 bus_enable,
  output logic [BUS_WIDTH-1:0] Sync_bus,
  output logic                 enable_pulse,
  output logic                 Ack_toggle,
  output logic                 Busy
);

  typedef enum logic {IDLE, WAIT_LOW} state_t;

  state_t                state_reg;
  logic [NUM_STAGES-1:0] en_s_reg;
  logic                  en_prev_reg;
  logic                  en_q;
  logic                  chain_low;
  logic                  capture;

  assign en_q      = en_s_reg[NUM_STAGES-1];
  // Re-arming requires the whole chain to be low, so a low gap shorter
  // than NUM_STAGES cycles merges adjacent words into one capture.
  assign chain_low = ~|en_s_reg;
  assign capture   = (state_reg == IDLE) && en_q && !en_prev_reg;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      en_s_reg     <= '0;
      en_prev_reg  <= 1'b0;
      state_reg    <= IDLE;
      Sync_bus     <= '0;
      enable_pulse <= 1'b0;
      Ack_toggle   <= 1'b0;
      Busy         <= 1'b0;
    end else begin
      en_s_reg     <= {en_s_reg[NUM_STAGES-2:0], bus_enable};
      en_prev_reg  <= en_q;
      enable_pulse <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (capture) begin
            Sync_bus     <= Unsync_bus;
            enable_pulse <= 1'b1;
            Ack_toggle   <= ~Ack_toggle;
            Busy         <= 1'b1;
            state_reg    <= WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          if (chain_low) begin
            Busy      <= 1'b0;
            state_reg <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_sync_rx.sv
// Scoreboard bench for data_sync_rx: stimulus queues expected captures,
// a negedge monitor pops and compares whenever enable_pulse is seen.
module tb_data_sync_rx;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] Unsync_bus = 8'hA5;
  logic       bus_enable = 1'b1;
  logic [7:0] Sync_bus;
  logic       enable_pulse;
  logic       Ack_toggle;
  logic       Busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [7:0] bus;
    logic       ack;
    int         cyc;
  } exp_t;
  exp_t exp_q[$];

  data_sync_rx #(.NUM_STAGES(2), .BUS_WIDTH(8)) dut (
    .CLK(CLK),
    .RST(RST),
    .Unsync_bus(Unsync_bus),
    .bus_enable(bus_enable),
    .Sync_bus(Sync_bus),
    .enable_pulse(enable_pulse),
    .Ack_toggle(Ack_toggle),
    .Busy(Busy)
  );

  always #50 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: %0h (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Raise enable with a word; the first sampling edge is cyc+1, so the pulse is seen after edge cyc+3.
  task automatic start_word(input logic [7:0] v, input logic expect_cap, input logic exp_ack);
    exp_t e;
    Unsync_bus = v;
    bus_enable = 1'b1;
    if (expect_cap) begin
      e.bus = v;
      e.ack = exp_ack;
      e.cyc = cyc + 3;
      exp_q.push_back(e);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (enable_pulse === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got pulse at cycle %0d with bus %0h, required no pulse", cyc, Sync_bus);
      end else begin
        e = exp_q.pop_front();
        check("pulse_cycle", 32'(cyc), 32'(e.cyc));
        check("pulse_sync_bus", 32'(Sync_bus), 32'(e.bus));
        check("pulse_ack_toggle", 32'(Ack_toggle), 32'(e.ack));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Test 1: outputs held clear while reset is asserted
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("reset_outputs", 32'({Sync_bus, enable_pulse, Ack_toggle, Busy}), 32'h0);
    end
    RST = 1'b1;
    bus_enable = 1'b0;
    step(3);

    // Test 2: single word, enable high 5 cycles
    start_word(8'h3C, 1'b1, 1'b1);
    step(5);
    bus_enable = 1'b0;
    step(2);
    check("t2_busy_still_high", 32'(Busy), 32'h1);
    step(1);
    check("t2_busy_fall", 32'(Busy), 32'h0);
    check("t2_sync_bus", 32'(Sync_bus), 32'h3C);
    check("t2_ack", 32'(Ack_toggle), 32'h1);
    step(2);

    // Test 3: long enable, bus changes mid-way
    start_word(8'h5A, 1'b1, 1'b0);
    step(6);
    Unsync_bus = 8'hFF;
    step(6);
    bus_enable = 1'b0;
    step(4);
    check("t3_sync_bus_hold", 32'(Sync_bus), 32'h5A);
    check("t3_busy_idle", 32'(Busy), 32'h0);

    // Test 4: two words separated by 3 low cycles
    start_word(8'h11, 1'b1, 1'b1);
    step(4);
    bus_enable = 1'b0;
    step(3);
    start_word(8'h22, 1'b1, 1'b0);
    step(4);
    bus_enable = 1'b0;
    step(4);
    check("t4_sync_bus", 32'(Sync_bus), 32'h22);
    check("t4_ack", 32'(Ack_toggle), 32'h0);

    // Test 5: 1-cycle low gap merges into one capture
    start_word(8'h11, 1'b1, 1'b1);
    step(4);
    bus_enable = 1'b0;
    step(1);
    start_word(8'h33, 1'b0, 1'b0);
    step(4);
    bus_enable = 1'b0;
    step(4);
    check("t5_sync_bus", 32'(Sync_bus), 32'h11);
    check("t5_ack", 32'(Ack_toggle), 32'h1);

    // Test 6: reset while busy with enable still high
    start_word(8'h77, 1'b1, 1'b0);
    step(4);
    check("t6_busy_before_reset", 32'(Busy), 32'h1);
    RST = 1'b0;
    step(1);
    check("t6_reset_outputs", 32'({Sync_bus, enable_pulse, Ack_toggle, Busy}), 32'h0);
    RST = 1'b1;
    start_word(8'h77, 1'b1, 1'b1);
    step(5);
    check("t6_ack", 32'(Ack_toggle), 32'h1);
    check("t6_sync_bus", 32'(Sync_bus), 32'h77);
    bus_enable = 1'b0;
    step(5);

    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
